// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised UART receiver with 3-sample majority vote, framing/break detection.
// Optional parity check is built when UART_RX_PARITY_EN is defined.
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic                 i_Rx_Serial,
`ifdef UART_RX_PARITY_EN
    input  logic                 i_Parity_Odd,
`endif
    output logic                 o_Rx_DV,
    output logic [DATA_BITS-1:0] o_Rx_Byte,
    output logic                 o_Frame_Err,
    output logic                 o_Parity_Err,
    output logic                 o_Break,
    output logic                 o_Busy
);

    localparam int CW  = $clog2(CLKS_PER_BIT);
    localparam int IW  = $clog2(DATA_BITS);
    localparam int MID = (CLKS_PER_BIT - 1) / 2;

    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] MID_M1   = CW'(MID - 1);
    localparam logic [CW-1:0] MID_C    = CW'(MID);
    localparam logic [CW-1:0] MID_P1   = CW'(MID + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);
    localparam logic          LAST_STP = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t                 state;
    logic                   rx_meta;
    logic                   rx;
    logic [CW-1:0]          cnt;
    logic [IW-1:0]          idx;
    logic                   stop_idx;
    logic [DATA_BITS-1:0]   data_sh;
    logic                   s_lo;
    logic                   s_mid;
    logic                   first_stop_zero;
`ifdef UART_RX_PARITY_EN
    logic                   parity_odd_q;
    logic                   parity_vote;
`endif

    logic bit_end;
    logic vote_now;
    logic vote_val;

    // Third sample is the live rx, so the vote lands in the register on the MID+1 edge.
    assign bit_end  = (cnt == LAST_CNT);
    assign vote_now = (cnt == MID_P1);
    assign vote_val = (s_lo & s_mid) | (s_lo & rx) | (s_mid & rx);

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state           <= S_IDLE;
            rx_meta         <= 1'b1;
            rx              <= 1'b1;
            cnt             <= '0;
            idx             <= '0;
            stop_idx        <= 1'b0;
            data_sh         <= '0;
            s_lo            <= 1'b0;
            s_mid           <= 1'b0;
            first_stop_zero <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_odd_q    <= 1'b0;
            parity_vote     <= 1'b0;
`endif
            o_Rx_DV         <= 1'b0;
            o_Rx_Byte       <= '0;
            o_Frame_Err     <= 1'b0;
            o_Parity_Err    <= 1'b0;
            o_Break         <= 1'b0;
            o_Busy          <= 1'b0;
        end else begin
            rx_meta      <= i_Rx_Serial;
            rx           <= rx_meta;
            o_Rx_DV      <= 1'b0;
            o_Frame_Err  <= 1'b0;
            o_Parity_Err <= 1'b0;
            o_Break      <= 1'b0;

            if (state != S_IDLE && state != S_WAIT_HIGH) begin
                cnt <= bit_end ? '0 : cnt + CW'(1);
                if (cnt == MID_M1) s_lo  <= rx;
                if (cnt == MID_C)  s_mid <= rx;
            end

            case (state)
                S_IDLE: begin
                    if (!rx) begin
                        state  <= S_START;
                        cnt    <= '0;
                        o_Busy <= 1'b1;
                    end
                end
                S_START: begin
                    if (vote_now) begin
                        if (vote_val) begin
                            state  <= S_IDLE;
                            o_Busy <= 1'b0;
                        end
`ifdef UART_RX_PARITY_EN
                        parity_odd_q <= i_Parity_Odd;
`endif
                    end else if (bit_end) begin
                        state <= S_DATA;
                        idx   <= '0;
                    end
                end
                S_DATA: begin
                    if (vote_now) begin
                        data_sh[idx] <= vote_val;
                    end else if (bit_end) begin
                        if (idx == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
                            state <= S_PARITY;
`else
                            state <= S_STOP;
`endif
                            stop_idx        <= 1'b0;
                            first_stop_zero <= 1'b0;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (vote_now) begin
                        parity_vote <= vote_val;
                    end else if (bit_end) begin
                        state <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (vote_now) begin
                        if (stop_idx == LAST_STP) begin
                            o_Rx_DV     <= 1'b1;
                            o_Rx_Byte   <= data_sh;
                            o_Frame_Err <= first_stop_zero | ~vote_val;
                            o_Break     <= (data_sh == '0) &&
                                           (stop_idx ? first_stop_zero : ~vote_val);
`ifdef UART_RX_PARITY_EN
                            o_Parity_Err <= ((^data_sh) ^ parity_vote) != parity_odd_q;
`endif
                            if (vote_val) begin
                                state  <= S_IDLE;
                                o_Busy <= 1'b0;
                            end else begin
                                state <= S_WAIT_HIGH;
                            end
                        end else begin
                            first_stop_zero <= ~vote_val;
                        end
                    end else if (bit_end) begin
                        stop_idx <= 1'b1;
                    end
                end
                S_WAIT_HIGH: begin
                    // A held-low line must not be mistaken for a new start bit.
                    if (rx) begin
                        state  <= S_IDLE;
                        o_Busy <= 1'b0;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    o_Busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - randomized self-checking bench for uart_rx_param with frame-level model.
module tb_uart_rx_param;

    localparam int C  = 16;
    localparam int DB = 8;
    localparam int SB = 1;
`ifdef UART_RX_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx_line = 1'b1;
    logic          parity_odd = 1'b0;
    logic          dv;
    logic [DB-1:0] rx_byte;
    logic          fe, pe, brk, busy;

    uart_rx_param #(.CLKS_PER_BIT(C), .DATA_BITS(DB), .STOP_BITS(SB)) dut (
        .i_Clock      (clk),
        .i_Reset      (rst),
        .i_Rx_Serial  (rx_line),
`ifdef UART_RX_PARITY_EN
        .i_Parity_Odd (parity_odd),
`endif
        .o_Rx_DV      (dv),
        .o_Rx_Byte    (rx_byte),
        .o_Frame_Err  (fe),
        .o_Parity_Err (pe),
        .o_Break      (brk),
        .o_Busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DB-1:0] data;
        logic          fe;
        logic          brk;
        logic          pe;
    } exp_t;

    exp_t          exp_q[$];
    logic [DB-1:0] got_q[$];
    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    int            n_dv = 0;
    int            dv_cyc = 0;
    logic          last_fe, last_brk, last_pe;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Every strobe must match the oldest outstanding frame; flags must be quiet otherwise.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!rst) begin
            if (dv) begin
                n_dv++;
                dv_cyc   = cyc;
                last_fe  = fe;
                last_brk = brk;
                last_pe  = pe;
                got_q.push_back(rx_byte);
                if (exp_q.size() == 0) begin
                    check("unexpected_dv", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("model_byte", rx_byte, e.data);
                    check("model_frame_err", fe, e.fe);
                    check("model_break", brk, e.brk);
                    check("model_parity_err", pe, e.pe);
                end
            end else begin
                check("idle_flags", {fe, brk, pe}, 0);
            end
        end
    end

    task automatic drive_bits(input logic v, input int n);
        rx_line = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [DB-1:0] d, input logic stop_v, input logic pbit);
        exp_t e;
        e.data = d;
        e.fe   = !stop_v;
        e.brk  = (d == '0) && !stop_v;
`ifdef UART_RX_PARITY_EN
        e.pe   = ((^d) ^ pbit) != parity_odd;
`else
        e.pe   = 1'b0;
`endif
        exp_q.push_back(e);
        drive_bits(1'b0, C);
        for (int i = 0; i < DB; i++) drive_bits(d[i], C);
`ifdef UART_RX_PARITY_EN
        drive_bits(pbit, C);
`endif
        drive_bits(stop_v, C * SB);
    endtask

    task automatic wait_idle(input string name, input int limit);
        int k = 0;
        while (busy && k < limit) begin
            @(negedge clk);
            k++;
        end
        check(name, busy, 0);
    endtask

    initial begin
        int            n0, start_cyc, lat;
        logic [DB-1:0] d;
        logic          sv;
        exp_t          eb;

        repeat (3) @(negedge clk);
        check("reset_dv", dv, 0);
        check("reset_byte", rx_byte, 0);
        check("reset_frame_err", fe, 0);
        check("reset_parity_err", pe, 0);
        check("reset_break", brk, 0);
        check("reset_busy", busy, 0);
        rst = 1'b0;
        drive_bits(1'b1, 2 * C);

        n0 = n_dv;
        start_cyc = cyc + 1;
        send_frame(8'hA5, 1'b1, ^8'hA5 ^ parity_odd);
        drive_bits(1'b1, 2 * C);
        lat = dv_cyc - start_cyc;
        check("a5_count", n_dv - n0, 1);
        check("a5_byte", got_q[got_q.size() - 1], 8'hA5);
        check("a5_flags", {last_fe, last_brk, last_pe}, 0);
        check("a5_latency_window", (lat >= 152 + 2 + PBITS * C) && (lat <= 156 + PBITS * C), 1);

        n0 = n_dv;
        drive_bits(1'b0, 3);
        check("glitch_busy_set", busy, 1);
        rx_line = 1'b1;
        wait_idle("glitch_busy_clear", 10);
        drive_bits(1'b1, 2 * C);
        check("glitch_no_dv", n_dv - n0, 0);

        got_q.delete();
        n0 = n_dv;
        send_frame(8'h3C, 1'b1, ^8'h3C ^ parity_odd);
        send_frame(8'hC3, 1'b1, ^8'hC3 ^ parity_odd);
        drive_bits(1'b1, 2 * C);
        check("b2b_count", n_dv - n0, 2);
        if (got_q.size() == 2) begin
            check("b2b_first", got_q[0], 8'h3C);
            check("b2b_second", got_q[1], 8'hC3);
        end

        send_frame(8'h5A, 1'b0, ^8'h5A ^ parity_odd);
        drive_bits(1'b0, 3 * C);
        check("stop0_byte", got_q[got_q.size() - 1], 8'h5A);
        check("stop0_frame_err", last_fe, 1);
        check("stop0_break", last_brk, 0);
        check("stop0_wait_high", busy, 1);
        rx_line = 1'b1;
        wait_idle("stop0_release", 6);
        drive_bits(1'b1, 2 * C);

        n0 = n_dv;
        eb.data = '0;
        eb.fe   = 1'b1;
        eb.brk  = 1'b1;
        eb.pe   = (PBITS == 1) ? parity_odd : 1'b0;
        exp_q.push_back(eb);
        drive_bits(1'b0, 20 * C);
        check("break_count", n_dv - n0, 1);
        check("break_byte", got_q[got_q.size() - 1], 0);
        check("break_flags", {last_fe, last_brk}, 2'b11);
        check("break_held", busy, 1);
        rx_line = 1'b1;
        wait_idle("break_release", 6);
        drive_bits(1'b1, 2 * C);

`ifdef UART_RX_PARITY_EN
        parity_odd = 1'b0;
        send_frame(8'h07, 1'b1, 1'b0);
        drive_bits(1'b1, C);
        check("parity_bad", last_pe, 1);
        send_frame(8'h07, 1'b1, 1'b1);
        drive_bits(1'b1, C);
        check("parity_good", last_pe, 0);
`endif

        n0 = n_dv;
        drive_bits(1'b0, C);
        drive_bits(1'b1, C);
        drive_bits(1'b0, C);
        drive_bits(1'b1, C / 2);
        rst = 1'b1;
        rx_line = 1'b1;
        @(negedge clk);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_dv", dv, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        drive_bits(1'b1, 2 * C);
        check("rst_mid_no_dv", n_dv - n0, 0);
        send_frame(8'h96, 1'b1, ^8'h96 ^ parity_odd);
        drive_bits(1'b1, 2 * C);
        check("post_rst_count", n_dv - n0, 1);
        check("post_rst_byte", got_q[got_q.size() - 1], 8'h96);

        for (int f = 0; f < 30; f++) begin
            d  = DB'($urandom);
            sv = ($urandom_range(0, 4) != 0);
            parity_odd = 1'($urandom);
            send_frame(d, sv, 1'($urandom));
            if (sv) drive_bits(1'b1, $urandom_range(0, 2 * C));
            else    drive_bits(1'b1, C + $urandom_range(0, C));
        end

        drive_bits(1'b1, 3 * C);
        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
